// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 responder: FSM states and default frame parameters.
package spi_pkg;

    localparam int unsigned SPI_DATA_W     = 8;
    localparam logic [7:0]  SPI_DEFAULT_TX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, plus an edge flop producing registered
// one-cycle rise/fall pulses aligned with the synchronized level.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= RST_VAL;
            sync  <= RST_VAL;
            level <= RST_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            meta  <= d;
            sync  <= meta;
            level <= sync;
            rise  <= sync & ~level;
            fall  <= ~sync & level;
        end
    end

endmodule

// File: rtl/spi_slave_resp.sv
// SPI mode-0 responder oversampled in the sys_clk domain: receives MSB-first bytes on MOSI
// and shifts out bytes from a one-entry holding register (DEFAULT_TX when empty) on MISO.
module spi_slave_resp
    import spi_pkg::*;
#(
    parameter int unsigned       DATA_W     = SPI_DATA_W,
    parameter logic [DATA_W-1:0] DEFAULT_TX = DATA_W'(SPI_DEFAULT_TX)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              spi_SCLK,
    input  logic              spi_MOSI,
    input  logic              spi_SS_n,
    output logic              spi_MISO,
    output logic              spi_MISO_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              underrun,
    output logic              abort
);

    localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic ss_level, ss_rise, ss_fall;

    sync_edge #(.RST_VAL(1'b0)) u_sclk (
        .clk(sys_clk), .rst(sys_rst), .d(spi_SCLK),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge #(.RST_VAL(1'b0)) u_mosi (
        .clk(sys_clk), .rst(sys_rst), .d(spi_MOSI),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Reset to "selected" so a reset with SS_n already low never fakes a select edge;
    // the resulting rise after reset with SS_n high lands harmlessly in IDLE.
    sync_edge #(.RST_VAL(1'b0)) u_ss (
        .clk(sys_clk), .rst(sys_rst), .d(spi_SS_n),
        .level(ss_level), .rise(ss_rise), .fall(ss_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_level, ss_level, mosi_rise, mosi_fall};

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic              frame_done;
    logic              chained;
    logic              pend_pop;
    logic              pend_under;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] hold_data;

    // A chained LOAD only peeks at the holding register; the pop or underrun is committed
    // on the first SCLK rise of that byte, so a frame ending at SS_n rise loses nothing.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            frame_done  <= 1'b0;
            chained     <= 1'b0;
            pend_pop    <= 1'b0;
            pend_under  <= 1'b0;
            shift_reg   <= '0;
            rx_shift    <= '0;
            hold_data   <= '0;
            spi_MISO    <= 1'b1;
            spi_MISO_oe <= 1'b0;
            tx_ready    <= 1'b1;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            underrun    <= 1'b0;
            abort       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            underrun <= 1'b0;
            abort    <= 1'b0;

            if (tx_valid && tx_ready) begin
                hold_data <= tx_data;
                tx_ready  <= 1'b0;
            end

            if (ss_rise) begin
                state       <= IDLE;
                bit_cnt     <= '0;
                frame_done  <= 1'b0;
                chained     <= 1'b0;
                pend_pop    <= 1'b0;
                pend_under  <= 1'b0;
                spi_MISO    <= 1'b1;
                spi_MISO_oe <= 1'b0;
                if (bit_cnt != '0) begin
                    abort <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (ss_fall) begin
                            state       <= LOAD;
                            chained     <= 1'b0;
                            spi_MISO_oe <= 1'b1;
                        end
                    end
                    LOAD: begin
                        state      <= ACTIVE;
                        frame_done <= 1'b0;
                        if (!tx_ready) begin
                            shift_reg <= hold_data;
                            spi_MISO  <= hold_data[DATA_W-1];
                        end else begin
                            shift_reg <= DEFAULT_TX;
                            spi_MISO  <= DEFAULT_TX[DATA_W-1];
                        end
                        if (chained) begin
                            pend_pop   <= !tx_ready;
                            pend_under <= tx_ready;
                        end else if (!tx_ready) begin
                            tx_ready <= 1'b1;
                        end else begin
                            underrun <= 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[DATA_W-2:0], mosi_level};
                            if (bit_cnt == '0) begin
                                pend_pop   <= 1'b0;
                                pend_under <= 1'b0;
                                if (pend_pop) begin
                                    tx_ready <= 1'b1;
                                end
                                if (pend_under) begin
                                    underrun <= 1'b1;
                                end
                            end
                            if (bit_cnt == LAST_BIT) begin
                                rx_data    <= {rx_shift[DATA_W-2:0], mosi_level};
                                rx_valid   <= 1'b1;
                                bit_cnt    <= '0;
                                frame_done <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end else if (sclk_fall) begin
                            if (frame_done) begin
                                state   <= LOAD;
                                chained <= 1'b1;
                            end else begin
                                shift_reg <= shift_reg << 1;
                                spi_MISO  <= shift_reg[DATA_W-2];
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
